// File: rtl/cpu_mem_responder.sv
// Word memory serving CPU fetch, read and store cycles, plus a byte-stream program loader that holds the CPU in reset.
// Define MEM_PARITY_EN to add a per-word even-parity bit with the par_inj/par_err ports.
module cpu_mem_responder #(
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [11:0]   cpu_addr,
    input  logic [15:0]   cpu_wdata,
    output logic [15:0]   cpu_rdata,
    input  logic          cpu_en,
    input  logic          cpu_rdwr,
    output logic          cpu_rst,
    input  logic          ld_mode,
    input  logic          ld_valid,
    input  logic [7:0]    ld_byte,
    output logic          ld_ready,
`ifdef MEM_PARITY_EN
    input  logic          par_inj,
    output logic          par_err,
`endif
    output logic [AW-1:0] ld_words
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] LD_LO = 2'd1;
    localparam logic [1:0] LD_HI = 2'd2;
    localparam logic [1:0] LD_WR = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          rst_q;
    logic [AW-1:0] words_q, words_d;
    logic [7:0]    lo_q, lo_d;
    logic [7:0]    hi_q, hi_d;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] cpu_idx;
    logic          cpu_rd;
    logic          cpu_wr;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [15:0]   mem_wdata;

    // Upper address bits deliberately alias onto the smaller memory.
    generate
        if (AW < 12) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^cpu_addr[11:AW];
        end
    endgenerate

    assign cpu_idx  = cpu_addr[AW-1:0];
    assign cpu_rd   = (state_q == RUN) && cpu_en && !cpu_rdwr;
    assign cpu_wr   = (state_q == RUN) && cpu_en && cpu_rdwr;
    assign rdata_d  = cpu_rd ? mem_q[cpu_idx] : rdata_q;

    assign cpu_rdata = rdata_q;
    assign cpu_rst   = rst_q;
    assign ld_words  = words_q;
    assign ld_ready  = (state_q == LD_LO) || (state_q == LD_HI);

    always_comb begin
        state_d   = state_q;
        words_d   = words_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        mem_we    = 1'b0;
        mem_waddr = cpu_idx;
        mem_wdata = cpu_wdata;
        case (state_q)
            RUN: begin
                mem_we = cpu_wr;
                if (ld_mode) begin
                    state_d = LD_LO;
                    words_d = '0;
                end
            end
            LD_LO: begin
                if (ld_valid) begin
                    lo_d    = ld_byte;
                    state_d = LD_HI;
                end else if (!ld_mode) begin
                    state_d = RUN;
                end
            end
            LD_HI: begin
                if (ld_valid) begin
                    hi_d    = ld_byte;
                    state_d = LD_WR;
                end else if (!ld_mode) begin
                    state_d = RUN;
                end
            end
            default: begin
                // The assembled word is always committed, even if the host has just left load mode.
                mem_we    = 1'b1;
                mem_waddr = words_q;
                mem_wdata = {hi_q, lo_q};
                words_d   = words_q + AW'(1);
                state_d   = ld_mode ? LD_LO : RUN;
            end
        endcase
    end

    // The CPU is held in reset for exactly as long as the next state is a loader state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            rdata_q <= '0;
            rst_q   <= 1'b1;
            words_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            rst_q   <= (state_d != RUN);
            words_q <= words_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

`ifdef MEM_PARITY_EN
    logic par_mem_q [DEPTH];
    logic par_err_q;
    logic par_wbit;

    assign par_wbit = (^mem_wdata) ^ par_inj;
    assign par_err  = par_err_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr]     <= mem_wdata;
            par_mem_q[mem_waddr] <= par_wbit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else if (cpu_rd) begin
            par_err_q <= (^mem_q[cpu_idx]) != par_mem_q[cpu_idx];
        end
    end
`else
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Randomised bench for cpu_mem_responder, checked every cycle against a transaction-level memory/loader model.
// Builds with or without MEM_PARITY_EN.
module tb_cpu_mem_responder;

    localparam int DEPTH = 16;
    localparam int AW = $clog2(DEPTH);

    logic          clock = 1'b0;
    logic          resetN;
    logic [11:0]   cpuAddr;
    logic [15:0]   cpuWdata;
    logic [15:0]   cpuRdata;
    logic          cpuEn;
    logic          cpuRdwr;
    logic          cpuRst;
    logic          ldMode;
    logic          ldValid;
    logic [7:0]    ldByte;
    logic          ldReady;
    logic [AW-1:0] ldWords;
`ifdef MEM_PARITY_EN
    logic          parInj;
    logic          parErr;
`endif

    cpu_mem_responder #(.DEPTH(DEPTH)) dut (
        .clk       (clock),
        .rst_n     (resetN),
        .cpu_addr  (cpuAddr),
        .cpu_wdata (cpuWdata),
        .cpu_rdata (cpuRdata),
        .cpu_en    (cpuEn),
        .cpu_rdwr  (cpuRdwr),
        .cpu_rst   (cpuRst),
        .ld_mode   (ldMode),
        .ld_valid  (ldValid),
        .ld_byte   (ldByte),
        .ld_ready  (ldReady),
`ifdef MEM_PARITY_EN
        .par_inj   (parInj),
        .par_err   (parErr),
`endif
        .ld_words  (ldWords)
    );

    always #5 clock = ~clock;

    // Model: a word array, a flag for "loading", the bytes gathered for the current word, and a pending-commit flag.
    logic [15:0] modelMem [DEPTH];
    logic [7:0]  byteQ [$];
    bit          loadActive;
    bit          writePending;
    int          expWords;
    logic [15:0] expRdata;
    bit          expRst;
`ifdef MEM_PARITY_EN
    bit          modelBad [DEPTH];
    bit          expParErr;
`endif
    int compared = 0;
    int mismatched = 0;

    function automatic void modelReset();
        loadActive   = 1'b0;
        writePending = 1'b0;
        byteQ.delete();
        expWords     = 0;
        expRdata     = 16'h0000;
        expRst       = 1'b1;
`ifdef MEM_PARITY_EN
        expParErr    = 1'b0;
`endif
    endfunction

    function automatic void modelStep();
        int a;
        a = int'(cpuAddr) % DEPTH;
        if (!loadActive) begin
            if (cpuEn && cpuRdwr) begin
                modelMem[a] = cpuWdata;
`ifdef MEM_PARITY_EN
                modelBad[a] = parInj;
`endif
            end else if (cpuEn) begin
                expRdata = modelMem[a];
`ifdef MEM_PARITY_EN
                expParErr = modelBad[a];
`endif
            end
            if (ldMode) begin
                loadActive   = 1'b1;
                writePending = 1'b0;
                byteQ.delete();
                expWords     = 0;
            end
            expRst = ldMode;
        end else if (writePending) begin
            modelMem[expWords] = {byteQ[1], byteQ[0]};
`ifdef MEM_PARITY_EN
            modelBad[expWords] = parInj;
`endif
            expWords = (expWords + 1) % DEPTH;
            byteQ.delete();
            writePending = 1'b0;
            if (!ldMode) begin
                loadActive = 1'b0;
                expRst     = 1'b0;
            end
        end else if (ldValid) begin
            byteQ.push_back(ldByte);
            if (byteQ.size() == 2) writePending = 1'b1;
        end else if (!ldMode) begin
            loadActive = 1'b0;
            byteQ.delete();
            expRst = 1'b0;
        end
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkVal("cpu_rdata", 32'(cpuRdata), 32'(expRdata));
        checkVal("cpu_rst", 32'(cpuRst), 32'(expRst));
        checkVal("ld_ready", 32'(ldReady), 32'(loadActive && !writePending));
        checkVal("ld_words", 32'(ldWords), 32'(expWords));
`ifdef MEM_PARITY_EN
        checkVal("par_err", 32'(parErr), 32'(expParErr));
`endif
    endtask

    task automatic applyStimulus(input logic en, input logic rdwr, input logic [11:0] addr,
                                 input logic [15:0] wd, input logic mode, input logic valid,
                                 input logic [7:0] b);
        cpuEn    = en;
        cpuRdwr  = rdwr;
        cpuAddr  = addr;
        cpuWdata = wd;
        ldMode   = mode;
        ldValid  = valid;
        ldByte   = b;
        modelStep();
        @(posedge clock);
        @(negedge clock);
        checkOutput();
    endtask

    task automatic idle(input logic mode);
        applyStimulus(1'b0, 1'b0, 12'h000, 16'h0000, mode, 1'b0, 8'h00);
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, b);
    endtask

    task automatic cpuWrite(input logic [11:0] addr, input logic [15:0] wd, input logic mode);
        applyStimulus(1'b1, 1'b1, addr, wd, mode, 1'b0, 8'h00);
    endtask

    task automatic cpuRead(input logic [11:0] addr);
        applyStimulus(1'b1, 1'b0, addr, 16'h0000, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [15:0] w;
        logic        mode;
        resetN   = 1'b0;
        cpuEn    = 1'b0;
        cpuRdwr  = 1'b0;
        cpuAddr  = 12'h000;
        cpuWdata = 16'h0000;
        ldMode   = 1'b0;
        ldValid  = 1'b0;
        ldByte   = 8'h00;
`ifdef MEM_PARITY_EN
        parInj   = 1'b0;
`endif
        modelReset();
        repeat (3) @(negedge clock);
        checkVal("reset cpu_rst", 32'(cpuRst), 32'd1);
        checkVal("reset cpu_rdata", 32'(cpuRdata), 32'h0000);
        checkVal("reset ld_words", 32'(ldWords), 32'd0);
        checkVal("reset ld_ready", 32'(ldReady), 32'd0);
        resetN = 1'b1;
        idle(1'b0);
        checkVal("cpu_rst released", 32'(cpuRst), 32'd0);

        // Two-word program load, then the CPU reads it back.
        idle(1'b1);
        checkVal("cpu_rst in load", 32'(cpuRst), 32'd1);
        sendByte(8'h34);
        sendByte(8'h12);
        idle(1'b1);
        sendByte(8'hCD);
        sendByte(8'hAB);
        idle(1'b0);
        checkVal("ld_words after load", 32'(ldWords), 32'd2);
        checkVal("cpu_rst after load", 32'(cpuRst), 32'd0);
        cpuRead(12'h000);
        checkVal("read loaded word 0", 32'(cpuRdata), 32'h1234);
        cpuRead(12'h001);
        checkVal("read loaded word 1", 32'(cpuRdata), 32'hABCD);

        // Store then read back, including aliased addresses.
        cpuWrite(12'h003, 16'h5A5A, 1'b0);
        cpuRead(12'h003);
        checkVal("write-read 0x003", 32'(cpuRdata), 32'h5A5A);
        cpuRead(12'h103);
        checkVal("alias 0x103", 32'(cpuRdata), 32'h5A5A);
        cpuRead(12'h013);
        checkVal("alias 0x013", 32'(cpuRdata), 32'h5A5A);

        // CPU store ignored in load mode; a lone byte is discarded on exit.
        idle(1'b1);
        cpuWrite(12'h000, 16'hDEAD, 1'b1);
        sendByte(8'h77);
        idle(1'b0);
        checkVal("ld_words after partial", 32'(ldWords), 32'd0);
        cpuRead(12'h000);
        checkVal("blocked store", 32'(cpuRdata), 32'h1234);

        // DEPTH+1 words with ld_valid held high: counter wraps, word DEPTH lands at address 0.
        idle(1'b1);
        for (int k = 0; k <= DEPTH; k++) begin
            w = 16'hC000 ^ (16'(k) * 16'h0111);
            sendByte(w[7:0]);
            sendByte(w[15:8]);
            applyStimulus(1'b0, 1'b0, 12'h000, 16'h0000, (k != DEPTH), 1'b1, 8'hEE);
        end
        checkVal("ld_words wrap", 32'(ldWords), 32'd1);
        cpuRead(12'h000);
        checkVal("wrapped word at 0", 32'(cpuRdata), 32'hD110);

        // Access in the same cycle ld_mode rises still completes.
        cpuWrite(12'h007, 16'h7777, 1'b1);
        idle(1'b0);
        cpuRead(12'h007);
        checkVal("store on load entry", 32'(cpuRdata), 32'h7777);

        // Reset in the middle of a word.
        idle(1'b1);
        sendByte(8'h11);
        sendByte(8'h22);
        idle(1'b1);
        sendByte(8'h99);
        ldMode  = 1'b0;
        ldValid = 1'b0;
        resetN  = 1'b0;
        #1;
        checkVal("midload reset cpu_rst", 32'(cpuRst), 32'd1);
        checkVal("midload reset ld_ready", 32'(ldReady), 32'd0);
        checkVal("midload reset ld_words", 32'(ldWords), 32'd0);
        checkVal("midload reset cpu_rdata", 32'(cpuRdata), 32'h0000);
        modelReset();
        @(negedge clock);
        resetN = 1'b1;
        idle(1'b0);
        cpuRead(12'h000);
        checkVal("memory kept over reset", 32'(cpuRdata), 32'h2211);

`ifdef MEM_PARITY_EN
        parInj = 1'b1;
        cpuWrite(12'h005, 16'h0001, 1'b0);
        parInj = 1'b0;
        cpuRead(12'h005);
        checkVal("parity injected", 32'(parErr), 32'd1);
        cpuRead(12'h006);
        checkVal("parity clean", 32'(parErr), 32'd0);
`endif

        mode = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom),
                          16'($urandom), mode, mode && ($urandom_range(0, 3) != 0), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
